// File: rtl/ce_pkg.sv
// Shared definitions for the channel-estimate datapath: coefficient format,
// stream error codes, frame FSM state and the per-sample side-band tag.
package ce_pkg;

    localparam int CE_COEF_W     = 18;
    localparam int CE_COEF_SHIFT = 16;
    localparam int CE_IDX_W      = 12;

    localparam logic [1:0] CE_ERR_OK  = 2'b00;
    localparam logic [1:0] CE_ERR_SOP = 2'b01;
    localparam logic [1:0] CE_ERR_LEN = 2'b10;

    typedef enum logic {
        CE_IDLE  = 1'b0,
        CE_FRAME = 1'b1
    } ce_state_t;

    // Side-band flags that travel with a sample through every pipeline stage.
    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [1:0] err;
    } ce_tag_t;

endpackage

// File: rtl/ce_round_sat.sv
// Round-half-up, arithmetic right shift by SHIFT, then saturate to W_OUT bits.
// Purely combinational; shared with the LS scaling path.
module ce_round_sat #(
    parameter int W_IN  = 35,
    parameter int W_OUT = 16,
    parameter int SHIFT = 16
) (
    input  logic signed [W_IN-1:0]  din,
    output logic signed [W_OUT-1:0] dout
);

    // One guard bit keeps the rounding bias from overflowing at full scale.
    localparam logic signed [W_IN:0] HALF = {{(W_IN-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [W_IN:0] MAXV = {{(W_IN-W_OUT+2){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_IN:0] MINV = {{(W_IN-W_OUT+2){1'b1}}, {(W_OUT-1){1'b0}}};

    logic signed [W_IN:0] biased;
    logic signed [W_IN:0] shifted;

    always_comb begin
        biased  = {din[W_IN-1], din} + HALF;
        shifted = biased >>> SHIFT;
        if (shifted > MAXV) begin
            dout = MAXV[W_OUT-1:0];
        end else if (shifted < MINV) begin
            dout = MINV[W_OUT-1:0];
        end else begin
            dout = shifted[W_OUT-1:0];
        end
    end

endmodule

// File: rtl/ce_rs_remod.sv
// Re-modulates a channel estimate with the reference signal: Y = H * X_rs.
// Five-register stream pipeline with frame tracking and external coefficient ROM.
module ce_rs_remod
    import ce_pkg::*;
#(
    parameter int wDataIn  = 16,
    parameter int wDataOut = 16,
    parameter int wCoeff   = CE_COEF_W,
    parameter int SHIFT    = CE_COEF_SHIFT
) (
    input  logic                       clk,
    input  logic                       rst_sync,
    input  logic                       sink_valid,
    output logic                       sink_ready,
    input  logic [1:0]                 sink_error,
    input  logic                       sink_sop,
    input  logic                       sink_eop,
    input  logic signed [wDataIn-1:0]  sink_real,
    input  logic signed [wDataIn-1:0]  sink_imag,
    input  logic [CE_IDX_W-1:0]        fftpts_in,
    output logic [CE_IDX_W-1:0]        coef_addr,
    output logic                       coef_rd_en,
    input  logic signed [wCoeff-1:0]   coef_real,
    input  logic signed [wCoeff-1:0]   coef_imag,
    output logic                       source_valid,
    input  logic                       source_ready,
    output logic [1:0]                 source_error,
    output logic                       source_sop,
    output logic                       source_eop,
    output logic signed [wDataOut-1:0] source_real,
    output logic signed [wDataOut-1:0] source_imag,
    output logic [CE_IDX_W-1:0]        fftpts_out
);

    localparam int PW = wDataIn + wCoeff;
    localparam int SW = PW + 1;

    logic en;
    logic acc;
    logic unused_err;

    assign en         = !source_valid || source_ready;
    assign sink_ready = en;
    assign acc        = sink_valid && en;
    assign unused_err = ^sink_error;

    // Frame tracking state.
    ce_state_t             state;
    logic [CE_IDX_W-1:0]   cnt;
    logic [CE_IDX_W:0]     n_len;

    // Per-sample decode of the incoming beat.
    logic [CE_IDX_W:0]     n_new;
    logic [CE_IDX_W:0]     n_cur;
    logic [CE_IDX_W-1:0]   s_idx;
    logic                  keep;
    logic                  is_last;
    logic                  len_err;
    ce_tag_t               s_tag;
    ce_state_t             nxt_state;

    always_comb begin
        // NOTE: every variable here is assigned on every path, so no latch can be inferred.
        n_new     = (fftpts_in == '0) ? 13'd4096 : {1'b0, fftpts_in};
        n_cur     = sink_sop ? n_new : n_len;
        keep      = sink_sop || (state == CE_FRAME);
        s_idx     = sink_sop ? '0 : cnt;
        is_last   = ({1'b0, s_idx} == (n_cur - 13'd1));
        len_err   = is_last ^ sink_eop;
        s_tag.sop = sink_sop;
        s_tag.eop = sink_eop || is_last;
        if (len_err) begin
            s_tag.err = CE_ERR_LEN;
        end else if (sink_sop && (state == CE_FRAME)) begin
            s_tag.err = CE_ERR_SOP;
        end else begin
            s_tag.err = CE_ERR_OK;
        end
        nxt_state = s_tag.eop ? CE_IDLE : CE_FRAME;
    end

    // Pipeline registers: p0 sample, p1 waiting for ROM data, p2 products, p3 sums.
    logic                       p0_valid, p1_valid, p2_valid, p3_valid;
    logic signed [wDataIn-1:0]  p0_a, p0_b, p1_a, p1_b;
    ce_tag_t                    p0_tag, p1_tag, p2_tag, p3_tag;
    logic signed [PW-1:0]       p2_ac, p2_bd, p2_ad, p2_bc;
    logic signed [SW-1:0]       p3_re, p3_im;
    logic                       rd_req;

    logic signed [wDataOut-1:0] y_re;
    logic signed [wDataOut-1:0] y_im;

    // The read is issued only on an advancing edge, so ROM data stays paired
    // with the sample sitting in p1 however long the output stalls.
    assign coef_rd_en = rd_req && en;

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            // NOTE: datapath registers are cleared as well, so nothing stale survives a reset.
            state        <= CE_IDLE;
            cnt          <= '0;
            n_len        <= '0;
            fftpts_out   <= '0;
            coef_addr    <= '0;
            rd_req       <= 1'b0;
            p0_valid     <= 1'b0;
            p0_a         <= '0;
            p0_b         <= '0;
            p0_tag       <= '0;
            p1_valid     <= 1'b0;
            p1_a         <= '0;
            p1_b         <= '0;
            p1_tag       <= '0;
            p2_valid     <= 1'b0;
            p2_ac        <= '0;
            p2_bd        <= '0;
            p2_ad        <= '0;
            p2_bc        <= '0;
            p2_tag       <= '0;
            p3_valid     <= 1'b0;
            p3_re        <= '0;
            p3_im        <= '0;
            p3_tag       <= '0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_error <= '0;
            source_real  <= '0;
            source_imag  <= '0;
        end else begin
            if (acc && keep) begin
                state     <= nxt_state;
                cnt       <= s_idx + 12'd1;
                coef_addr <= s_idx;
                if (sink_sop) begin
                    n_len      <= n_cur;
                    fftpts_out <= fftpts_in;
                end
            end

            if (en) begin
                // Samples outside a frame are consumed but never enter the pipe.
                p0_valid <= acc && keep;
                rd_req   <= acc && keep;
                p0_a     <= sink_real;
                p0_b     <= sink_imag;
                p0_tag   <= s_tag;

                p1_valid <= p0_valid;
                p1_a     <= p0_a;
                p1_b     <= p0_b;
                p1_tag   <= p0_tag;

                p2_valid <= p1_valid;
                p2_ac    <= PW'(p1_a) * PW'(coef_real);
                p2_bd    <= PW'(p1_b) * PW'(coef_imag);
                p2_ad    <= PW'(p1_a) * PW'(coef_imag);
                p2_bc    <= PW'(p1_b) * PW'(coef_real);
                p2_tag   <= p1_tag;

                p3_valid <= p2_valid;
                p3_re    <= SW'(p2_ac) - SW'(p2_bd);
                p3_im    <= SW'(p2_ad) + SW'(p2_bc);
                p3_tag   <= p2_tag;

                source_valid <= p3_valid;
                source_sop   <= p3_tag.sop;
                source_eop   <= p3_tag.eop;
                source_error <= p3_tag.err;
                source_real  <= y_re;
                source_imag  <= y_im;
            end
        end
    end

    ce_round_sat #(
        .W_IN  (SW),
        .W_OUT (wDataOut),
        .SHIFT (SHIFT)
    ) u_fmt_re (
        .din  (p3_re),
        .dout (y_re)
    );

    ce_round_sat #(
        .W_IN  (SW),
        .W_OUT (wDataOut),
        .SHIFT (SHIFT)
    ) u_fmt_im (
        .din  (p3_im),
        .dout (y_im)
    );

endmodule

// File: tb/tb_ce_rs_remod.sv
// Scoreboard bench for ce_rs_remod: a frame-level reference model predicts every
// output sample and ROM address; a separate monitor pops and compares them.
module tb_ce_rs_remod;
    import ce_pkg::*;

    localparam int WI = 16;
    localparam int WO = 16;
    localparam int WC = 18;
    localparam int SH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_sync;
    logic                 sink_valid;
    logic                 sink_ready;
    logic [1:0]           sink_error;
    logic                 sink_sop;
    logic                 sink_eop;
    logic signed [WI-1:0] sink_real;
    logic signed [WI-1:0] sink_imag;
    logic [11:0]          fftpts_in;
    logic [11:0]          coef_addr;
    logic                 coef_rd_en;
    logic signed [WC-1:0] coef_real;
    logic signed [WC-1:0] coef_imag;
    logic                 source_valid;
    logic                 source_ready;
    logic [1:0]           source_error;
    logic                 source_sop;
    logic                 source_eop;
    logic signed [WO-1:0] source_real;
    logic signed [WO-1:0] source_imag;
    logic [11:0]          fftpts_out;

    ce_rs_remod #(
        .wDataIn  (WI),
        .wDataOut (WO),
        .wCoeff   (WC),
        .SHIFT    (SH)
    ) dut (
        .clk          (clk),
        .rst_sync     (rst_sync),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_error   (sink_error),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .fftpts_in    (fftpts_in),
        .coef_addr    (coef_addr),
        .coef_rd_en   (coef_rd_en),
        .coef_real    (coef_real),
        .coef_imag    (coef_imag),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_error (source_error),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .fftpts_out   (fftpts_out)
    );

    // Coefficient ROM with one cycle of read latency.
    logic signed [WC-1:0] rom_re [4096];
    logic signed [WC-1:0] rom_im [4096];

    always @(posedge clk) begin
        if (coef_rd_en) begin
            coef_real <= rom_re[coef_addr];
            coef_imag <= rom_im[coef_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected output beat: flags plus formatted real/imag.
    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [1:0]  err;
        logic [15:0] re;
        logic [15:0] im;
    } out_t;

    out_t exp_q[$];
    int   addr_q[$];

    // Reference model: frame position bookkeeping plus plain complex arithmetic.
    bit m_in_frame = 1'b0;
    int m_len      = 0;
    int m_pos      = 0;

    function automatic logic [15:0] fmt(input longint v);
        longint r;
        r = (v + (longint'(1) <<< (SH - 1))) >>> SH;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic model_accept(input logic sop, input logic eop, input int a, input int b,
                                input logic [11:0] n);
        out_t   e;
        bit     restart;
        bit     final_s;
        int     pos;
        longint c;
        longint d;
        if (!sop && !m_in_frame) return;
        restart = sop && m_in_frame;
        if (sop) begin
            m_len = (n == 12'd0) ? 4096 : int'(n);
            m_pos = 0;
        end
        pos     = m_pos;
        final_s = (pos == m_len - 1);
        c       = longint'(rom_re[pos]);
        d       = longint'(rom_im[pos]);
        e.sop   = sop;
        e.eop   = eop || final_s;
        e.err   = (final_s != eop) ? 2'b10 : (restart ? 2'b01 : 2'b00);
        e.re    = fmt(longint'(a) * c - longint'(b) * d);
        e.im    = fmt(longint'(a) * d + longint'(b) * c);
        exp_q.push_back(e);
        addr_q.push_back(pos);
        m_in_frame = !(eop || final_s);
        m_pos      = pos + 1;
    endtask

    // Output-side ready pattern: 0 always ready, 1 repeating 1,0,0,1, 2 random.
    int mode = 0;
    int ph   = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        source_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (mode)
                0:       source_ready = 1'b1;
                1:       begin source_ready = pat[ph % 4]; ph++; end
                default: source_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Latency probe.
    bit lat_arm  = 1'b0;
    bit acc_mark = 1'b0;
    int acc_cyc  = 0;
    int lat_cyc  = 0;

    // Monitor: everything is stable 2 time units after the falling edge.
    initial begin
        out_t got;
        out_t e;
        int   ea;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_sync) begin
                if (coef_rd_en) begin
                    ea = (addr_q.size() != 0) ? addr_q.pop_front() : -1;
                    check("coef_addr", 64'(coef_addr), 64'(ea));
                end
                if (lat_arm && source_valid) begin
                    lat_cyc = cyc;
                    lat_arm = 1'b0;
                end
                if (source_valid && source_ready) begin
                    got = {source_sop, source_eop, source_error, source_real, source_imag};
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out", 64'(got), 64'(e));
                    end else begin
                        check("out_unexpected", 64'(got), '1);
                    end
                end
            end
        end
    end

    task automatic send(input logic sop, input logic eop, input int a, input int b,
                        input logic [11:0] n);
        int w = 0;
        sink_valid = 1'b1;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_real  = a[15:0];
        sink_imag  = b[15:0];
        fftpts_in  = n;
        sink_error = 2'($urandom_range(0, 3));
        #1;
        while (!sink_ready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!sink_ready) begin
            check("sink_ready_timeout", 64'(sink_ready), 64'(1));
        end else begin
            model_accept(sop, eop, a, b, n);
            if (acc_mark) begin
                acc_cyc  = cyc + 1;
                acc_mark = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int w = 0;
        idle(0);
        while ((exp_q.size() != 0 || addr_q.size() != 0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("drain_exp", 64'(exp_q.size()), 64'(0));
        check("drain_addr", 64'(addr_q.size()), 64'(0));
        idle(2);
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    int ha [8];
    int hb [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_sync   = 1'b1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        sink_real  = '0;
        sink_imag  = '0;
        sink_error = '0;
        fftpts_in  = '0;
        coef_real  = '0;
        coef_imag  = '0;
        for (int i = 0; i < 4096; i++) begin
            rom_re[i] = '0;
            rom_im[i] = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state.
        check("reset_outputs",
              64'({source_valid, source_sop, source_eop, source_error, source_real,
                   source_imag, fftpts_out, coef_addr, coef_rd_en}), 64'(0));
        check("reset_sink_ready", 64'(sink_ready), 64'(1));
        rst_sync = 1'b0;
        @(negedge clk);

        // Unity coefficient, N=4, with latency probe.
        for (int i = 0; i < 4; i++) begin
            rom_re[i] = 18'sd65536;
            rom_im[i] = 18'sd0;
        end
        lat_arm  = 1'b1;
        acc_mark = 1'b1;
        for (int i = 0; i < 4; i++) send(i == 0, i == 3, 1000, 0, 12'd4);
        drain();
        check("latency", 64'(lat_cyc - acc_cyc), 64'(4));
        check("fftpts_out", 64'(fftpts_out), 64'(4));

        // j rotation and saturation.
        rom_re[0] = 18'sd0;     rom_im[0] = 18'sd65536;
        rom_re[1] = 18'sd65536; rom_im[1] = 18'sd65536;
        send(1'b1, 1'b0, 100, 200, 12'd2);
        send(1'b0, 1'b1, 32767, 32767, 12'd2);
        drain();

        // Random coefficients everywhere from here on.
        for (int i = 0; i < 4096; i++) begin
            rom_re[i] = 18'($urandom());
            rom_im[i] = 18'($urandom());
        end

        // Same N=8 symbol without and with output stalls.
        for (int i = 0; i < 8; i++) begin
            ha[i] = rnd16();
            hb[i] = rnd16();
        end
        for (int i = 0; i < 8; i++) send(i == 0, i == 7, ha[i], hb[i], 12'd8);
        drain();
        mode = 1;
        for (int i = 0; i < 8; i++) send(i == 0, i == 7, ha[i], hb[i], 12'd8);
        drain();

        // Early eop at the 5th sample, then a clean frame.
        mode = 2;
        for (int i = 0; i < 5; i++) send(i == 0, i == 4, rnd16(), rnd16(), 12'd8);
        for (int i = 0; i < 4; i++) send(i == 0, i == 3, rnd16(), rnd16(), 12'd4);
        drain();

        // New sop at the 3rd sample restarts the symbol.
        send(1'b1, 1'b0, rnd16(), rnd16(), 12'd8);
        send(1'b0, 1'b0, rnd16(), rnd16(), 12'd8);
        for (int i = 0; i < 8; i++) send(i == 0, i == 7, rnd16(), rnd16(), 12'd8);
        drain();

        // Drops outside a frame, single-sample symbols and sop+eop length errors.
        for (int i = 0; i < 3; i++) send(1'b0, 1'($urandom_range(0, 1)), rnd16(), rnd16(), 12'd5);
        send(1'b1, 1'b1, rnd16(), rnd16(), 12'd1);
        send(1'b1, 1'b1, rnd16(), rnd16(), 12'd3);
        send(1'b0, 1'b0, rnd16(), rnd16(), 12'd3);
        send(1'b1, 1'b0, rnd16(), rnd16(), 12'd1);
        send(1'b0, 1'b0, rnd16(), rnd16(), 12'd1);
        drain();

        // Random frames: random length, early eop, missing eop, stray samples.
        for (int f = 0; f < 8; f++) begin
            int  n;
            int  last;
            bit  no_eop;
            n      = int'($urandom_range(1, 24));
            last   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : n - 1;
            no_eop = ($urandom_range(0, 4) == 0);
            send(1'b0, 1'b0, rnd16(), rnd16(), 12'(n));
            for (int i = 0; i <= last; i++)
                send(i == 0, (i == last) && !no_eop, rnd16(), rnd16(), 12'(n));
        end
        drain();

        // N=0 means 4096 subcarriers.
        mode = 0;
        for (int i = 0; i < 4096; i++) send(i == 0, i == 4095, rnd16(), rnd16(), 12'd0);
        drain();

        // Reset mid-frame discards in-flight samples; stray samples then drop.
        for (int i = 0; i < 3; i++) send(i == 0, 1'b0, rnd16(), rnd16(), 12'd8);
        sink_valid = 1'b0;
        rst_sync   = 1'b1;
        exp_q.delete();
        addr_q.delete();
        m_in_frame = 1'b0;
        @(negedge clk);
        rst_sync = 1'b0;
        check("valid_after_reset", 64'(source_valid), 64'(0));
        check("fftpts_after_reset", 64'(fftpts_out), 64'(0));
        send(1'b0, 1'b0, rnd16(), rnd16(), 12'd8);
        send(1'b0, 1'b1, rnd16(), rnd16(), 12'd8);
        for (int i = 0; i < 2; i++) send(i == 0, i == 1, rnd16(), rnd16(), 12'd2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
